// File: rtl/os_receiver_if.sv
// AXI-Stream style bus carrying merged multi-lane ordered-set beats into os_receiver.
//   tdata  : lane i symbol k at [DATA_WIDTH*i + 8*k +: 8]
//   tkeep  : per-lane byte keep (not interpreted by the receiver)
//   tuser  : bit USER_WIDTH*i + k marks symbol k of lane i as a K-character
//   tvalid : beat valid
//   tlast  : last beat of an ordered set
//   tready : beat accepted when tvalid & tready
// Modports: master (stream source), slave (os_receiver).
interface os_receiver_if #(
    parameter int unsigned MAX_NUM_LANES = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH    = 4
) ();
    logic [DATA_WIDTH*MAX_NUM_LANES-1:0] tdata;
    logic [KEEP_WIDTH*MAX_NUM_LANES-1:0] tkeep;
    logic [USER_WIDTH*MAX_NUM_LANES-1:0] tuser;
    logic                                tvalid;
    logic                                tlast;
    logic                                tready;

    modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/os_receiver.sv
// Ordered-set receiver: decodes TS1/TS2 (4 beats) and EIOS (1 beat) from the merged multi-lane
// stream and reports the set, its type and its back-to-back repeat count to the LTSSM.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   s_axis              slave stream (os_receiver_if.slave)
//   active_lanes_i      lanes checked; lane 0 always treated as active
//   os_valid_o          one-cycle pulse, decoded TS/EIOS available
//   os_type_o           0 none, 1 TS1, 2 TS2, 3 EIOS
//   ordered_set_o       16 symbols per lane of the last valid TS, symbol 0 at bits [7:0]
//   consecutive_cnt_o   back-to-back identical TS count, saturating at 255
//   lane_err_o          per-lane identifier mismatch for the last TS
//   frame_err_o         one-cycle pulse on framing error
//   ts1_cnt_o, ts2_cnt_o, err_cnt_o  saturating statistics counters
// Macro OS_RX_STATS_EN builds the statistics counters; otherwise those ports are tied to 0.
module os_receiver #(
    parameter int unsigned MAX_NUM_LANES = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int unsigned USER_WIDTH    = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    os_receiver_if.slave               s_axis,
    input  logic [MAX_NUM_LANES-1:0]   active_lanes_i,
    output logic                       os_valid_o,
    output logic [1:0]                 os_type_o,
    output logic [128*MAX_NUM_LANES-1:0] ordered_set_o,
    output logic [7:0]                 consecutive_cnt_o,
    output logic [MAX_NUM_LANES-1:0]   lane_err_o,
    output logic                       frame_err_o,
    output logic [15:0]                ts1_cnt_o,
    output logic [15:0]                ts2_cnt_o,
    output logic [15:0]                err_cnt_o
);
    typedef enum logic [1:0] {ST_HUNT, ST_COLLECT, ST_DISCARD, ST_CHECK} state_t;

    state_t                         r_state;
    logic                           r_tready;
    logic [1:0]                     r_beat_cnt;
    logic                           r_is_eios;
    logic [128*MAX_NUM_LANES-1:0]   r_buf;
    logic [128*MAX_NUM_LANES-1:0]   r_os;
    logic                           r_os_valid;
    logic [1:0]                     r_os_type;
    logic [7:0]                     r_cons_cnt;
    logic [MAX_NUM_LANES-1:0]       r_lane_err;
    logic                           r_frame_err;
    logic [1:0]                     r_prev_type;
    logic [119:0]                   r_prev_syms;

    logic                           w_hs;
    logic [MAX_NUM_LANES-1:0]       w_active;
    logic                           w_com_ok;
    logic                           w_eios_syms;
    logic [7:0]                     w_sym6;
    logic [1:0]                     w_ts_type;
    logic                           w_match;
    logic [MAX_NUM_LANES-1:0]       w_lane_err;
    logic                           w_unused;

    assign w_unused    = ^s_axis.tkeep;
    assign w_hs        = s_axis.tvalid & r_tready;
    assign w_active    = active_lanes_i | MAX_NUM_LANES'(1);
    assign w_eios_syms = (s_axis.tdata[31:8] == 24'h7C7C7C) && (s_axis.tuser[3:1] == 3'b111);
    assign w_sym6      = r_buf[55:48];
    assign w_ts_type   = (w_sym6 == 8'h4A) ? 2'd1 : (w_sym6 == 8'h45) ? 2'd2 : 2'd0;
    assign w_match     = (w_ts_type == r_prev_type) && (r_buf[127:8] == r_prev_syms);

    // Every active lane must open beat 0 with a K-coded COM.
    always_comb begin
        w_com_ok = 1'b1;
        for (int i = 0; i < int'(MAX_NUM_LANES); i++) begin
            if (w_active[i] && ((s_axis.tdata[DATA_WIDTH*i +: 8] != 8'hBC) ||
                                !s_axis.tuser[USER_WIDTH*i])) begin
                w_com_ok = 1'b0;
            end
        end
    end

    // Identifier symbols 6..15 of each active lane must all match lane 0 symbol 6.
    always_comb begin
        w_lane_err = '0;
        for (int i = 0; i < int'(MAX_NUM_LANES); i++) begin
            for (int k = 6; k < 16; k++) begin
                if (w_active[i] && (r_buf[128*i + 8*k +: 8] != w_sym6)) begin
                    w_lane_err[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_HUNT;
            r_tready    <= 1'b0;
            r_beat_cnt  <= 2'd0;
            r_is_eios   <= 1'b0;
            r_buf       <= '0;
            r_os        <= '0;
            r_os_valid  <= 1'b0;
            r_os_type   <= 2'd0;
            r_cons_cnt  <= 8'd0;
            r_lane_err  <= '0;
            r_frame_err <= 1'b0;
            r_prev_type <= 2'd0;
            r_prev_syms <= '0;
        end else begin
            r_os_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_state)
                ST_HUNT: begin
                    r_tready <= 1'b1;
                    if (w_hs) begin
                        if (!w_com_ok) begin
                            r_frame_err <= 1'b1;
                            r_cons_cnt  <= 8'd0;
                        end else if (s_axis.tlast) begin
                            if (w_eios_syms) begin
                                r_is_eios <= 1'b1;
                                r_tready  <= 1'b0;
                                r_state   <= ST_CHECK;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_cons_cnt  <= 8'd0;
                            end
                        end else begin
                            for (int i = 0; i < int'(MAX_NUM_LANES); i++) begin
                                r_buf[128*i +: 32] <= s_axis.tdata[DATA_WIDTH*i +: 32];
                            end
                            r_is_eios  <= 1'b0;
                            r_beat_cnt <= 2'd1;
                            r_state    <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    r_tready <= 1'b1;
                    if (w_hs) begin
                        for (int i = 0; i < int'(MAX_NUM_LANES); i++) begin
                            r_buf[128*i + 32*int'(r_beat_cnt) +: 32] <=
                                s_axis.tdata[DATA_WIDTH*i +: 32];
                        end
                        if (r_beat_cnt == 2'd3) begin
                            if (s_axis.tlast) begin
                                r_tready <= 1'b0;
                                r_state  <= ST_CHECK;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_cons_cnt  <= 8'd0;
                                r_state     <= ST_DISCARD;
                            end
                        end else if (s_axis.tlast) begin
                            r_frame_err <= 1'b1;
                            r_cons_cnt  <= 8'd0;
                            r_state     <= ST_HUNT;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 2'd1;
                        end
                    end
                end
                ST_DISCARD: begin
                    r_tready <= 1'b1;
                    if (w_hs && s_axis.tlast) begin
                        r_state <= ST_HUNT;
                    end
                end
                ST_CHECK: begin
                    r_tready <= 1'b1;
                    r_state  <= ST_HUNT;
                    if (r_is_eios) begin
                        r_os_valid <= 1'b1;
                        r_os_type  <= 2'd3;
                        r_cons_cnt <= 8'd0;
                    end else if (w_ts_type != 2'd0) begin
                        r_os_valid  <= 1'b1;
                        r_os_type   <= w_ts_type;
                        r_os        <= r_buf;
                        r_lane_err  <= w_lane_err;
                        r_cons_cnt  <= !w_match ? 8'd1 :
                                       (r_cons_cnt != 8'hFF) ? r_cons_cnt + 8'd1 : 8'hFF;
                        r_prev_type <= w_ts_type;
                        r_prev_syms <= r_buf[127:8];
                    end else begin
                        r_frame_err <= 1'b1;
                        r_cons_cnt  <= 8'd0;
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    assign s_axis.tready     = r_tready;
    assign os_valid_o        = r_os_valid;
    assign os_type_o         = r_os_type;
    assign ordered_set_o     = r_os;
    assign consecutive_cnt_o = r_cons_cnt;
    assign lane_err_o        = r_lane_err;
    assign frame_err_o       = r_frame_err;

`ifdef OS_RX_STATS_EN
    logic [15:0] r_ts1_cnt;
    logic [15:0] r_ts2_cnt;
    logic [15:0] r_err_cnt;

    // Counted from the registered pulses, so they trail the event by one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ts1_cnt <= 16'd0;
            r_ts2_cnt <= 16'd0;
            r_err_cnt <= 16'd0;
        end else begin
            if (r_os_valid && (r_os_type == 2'd1) && (r_ts1_cnt != 16'hFFFF)) begin
                r_ts1_cnt <= r_ts1_cnt + 16'd1;
            end
            if (r_os_valid && (r_os_type == 2'd2) && (r_ts2_cnt != 16'hFFFF)) begin
                r_ts2_cnt <= r_ts2_cnt + 16'd1;
            end
            if (r_frame_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign ts1_cnt_o = r_ts1_cnt;
    assign ts2_cnt_o = r_ts2_cnt;
    assign err_cnt_o = r_err_cnt;
`else
    assign ts1_cnt_o = 16'd0;
    assign ts2_cnt_o = 16'd0;
    assign err_cnt_o = 16'd0;
`endif
endmodule

// File: tb/tb_os_receiver.sv
module tb_os_receiver;
    localparam int unsigned L = 4;

    logic           clk_i = 1'b0;
    logic           rst_ni = 1'b0;
    logic [L-1:0]   active_lanes_i = 4'hF;
    logic           os_valid_o;
    logic [1:0]     os_type_o;
    logic [128*L-1:0] ordered_set_o;
    logic [7:0]     consecutive_cnt_o;
    logic [L-1:0]   lane_err_o;
    logic           frame_err_o;
    logic [15:0]    ts1_cnt_o, ts2_cnt_o, err_cnt_o;

    os_receiver_if #(.MAX_NUM_LANES(L), .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4)) u_if ();

    os_receiver #(.MAX_NUM_LANES(L), .DATA_WIDTH(32), .KEEP_WIDTH(4), .USER_WIDTH(4)) u_dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .s_axis            (u_if),
        .active_lanes_i    (active_lanes_i),
        .os_valid_o        (os_valid_o),
        .os_type_o         (os_type_o),
        .ordered_set_o     (ordered_set_o),
        .consecutive_cnt_o (consecutive_cnt_o),
        .lane_err_o        (lane_err_o),
        .frame_err_o       (frame_err_o),
        .ts1_cnt_o         (ts1_cnt_o),
        .ts2_cnt_o         (ts2_cnt_o),
        .err_cnt_o         (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic         is_ferr;
        logic [1:0]   typ;
        logic [7:0]   cnt;
        logic [L-1:0] lerr;
        logic [127:0] lane0;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [1:0]   m_prev_t = 2'd0;
    logic [119:0] m_prev_syms = '0;
    int           m_cnt = 0;
    logic [127:0] m_last_os = '0;
    logic [L-1:0] m_last_lerr = '0;
    int           m_ts1 = 0, m_ts2 = 0, m_err = 0;

    task automatic model_reset();
        m_prev_t = 2'd0; m_prev_syms = '0; m_cnt = 0; m_last_os = '0; m_last_lerr = '0;
        m_ts1 = 0; m_ts2 = 0; m_err = 0;
    endtask

    task automatic exp_ts(input logic [511:0] os, input logic [1:0] t, input logic [L-1:0] lerr);
        exp_t e;
        if (t == m_prev_t && os[127:8] == m_prev_syms) m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        else m_cnt = 1;
        m_prev_t = t; m_prev_syms = os[127:8]; m_last_os = os[127:0]; m_last_lerr = lerr;
        if (t == 2'd1) m_ts1++; else m_ts2++;
        e.is_ferr = 1'b0; e.typ = t; e.cnt = 8'(m_cnt); e.lerr = lerr; e.lane0 = os[127:0];
        sb_q.push_back(e);
    endtask

    task automatic exp_eios();
        exp_t e;
        m_cnt = 0;
        e.is_ferr = 1'b0; e.typ = 2'd3; e.cnt = 8'd0; e.lerr = m_last_lerr; e.lane0 = m_last_os;
        sb_q.push_back(e);
    endtask

    task automatic exp_ferr();
        exp_t e;
        m_cnt = 0; m_err++;
        e.is_ferr = 1'b1; e.typ = 2'd0; e.cnt = 8'd0; e.lerr = '0; e.lane0 = '0;
        sb_q.push_back(e);
    endtask

    function automatic logic [511:0] mk_ts(input logic [7:0] id, input logic [7:0] nfts);
        logic [511:0] os;
        for (int i = 0; i < int'(L); i++) begin
            os[128*i +: 8]      = 8'hBC;
            os[128*i + 8 +: 8]  = 8'hF7;
            os[128*i + 16 +: 8] = 8'(i);
            os[128*i + 24 +: 8] = nfts;
            os[128*i + 32 +: 8] = 8'h02;
            os[128*i + 40 +: 8] = 8'h00;
            for (int k = 6; k < 16; k++) os[128*i + 8*k +: 8] = id;
        end
        return os;
    endfunction

    task automatic send_beats(input logic [511:0] os, input int first, input int last,
                              input int last_at, input logic eios);
        for (int b = first; b <= last; b++) begin
            int guard;
            @(negedge clk_i);
            for (int i = 0; i < int'(L); i++) begin
                u_if.tdata[32*i +: 32] = os[128*i + 32*(b % 4) +: 32];
                u_if.tuser[4*i +: 4]   = eios ? 4'hF : ((b % 4) == 0 ? 4'h1 : 4'h0);
            end
            u_if.tkeep  = '1;
            u_if.tlast  = (b == last_at);
            u_if.tvalid = 1'b1;
            guard = 0;
            while (!u_if.tready && guard < 100) begin
                @(negedge clk_i);
                guard++;
            end
            if (guard >= 100) check_val("tready_timeout", 0, 1);
            @(posedge clk_i);
        end
        #1 u_if.tvalid = 1'b0;
        u_if.tlast = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(negedge clk_i);
            guard++;
        end
        check_val("drain", 128'(sb_q.size()), 0);
        repeat (3) @(negedge clk_i);
    endtask

    task automatic check_stats(input string tag);
`ifdef OS_RX_STATS_EN
        check_val({tag, "_ts1"}, 128'(ts1_cnt_o), 128'(m_ts1));
        check_val({tag, "_ts2"}, 128'(ts2_cnt_o), 128'(m_ts2));
        check_val({tag, "_err"}, 128'(err_cnt_o), 128'(m_err));
`else
        check_val({tag, "_ts1"}, 128'(ts1_cnt_o), 0);
        check_val({tag, "_ts2"}, 128'(ts2_cnt_o), 0);
        check_val({tag, "_err"}, 128'(err_cnt_o), 0);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_valid"}, 128'(os_valid_o), 0);
        check_val({tag, "_type"}, 128'(os_type_o), 0);
        check_val({tag, "_os"}, ordered_set_o[127:0], 0);
        check_val({tag, "_cnt"}, 128'(consecutive_cnt_o), 0);
        check_val({tag, "_lerr"}, 128'(lane_err_o), 0);
        check_val({tag, "_ferr"}, 128'(frame_err_o), 0);
        check_val({tag, "_tready"}, 128'(u_if.tready), 0);
        check_val({tag, "_stats"}, 128'({ts1_cnt_o, ts2_cnt_o, err_cnt_o}), 0);
    endtask

    // Output monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk_i) begin
        if (rst_ni && (os_valid_o || frame_err_o)) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_pulse", 128'({os_valid_o, frame_err_o}), 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("ferr_pulse", 128'(frame_err_o), 128'(e.is_ferr));
                check_val("valid_pulse", 128'(os_valid_o), 128'(!e.is_ferr));
                check_val("cnt", 128'(consecutive_cnt_o), 128'(e.cnt));
                if (!e.is_ferr) begin
                    check_val("type", 128'(os_type_o), 128'(e.typ));
                    check_val("lane_err", 128'(lane_err_o), 128'(e.lerr));
                    check_val("os_lane0", ordered_set_o[127:0], e.lane0);
                end
            end
        end
    end

    initial begin
        logic [511:0] ts;
        logic [511:0] eios;
        u_if.tvalid = 1'b0; u_if.tlast = 1'b0; u_if.tdata = '0; u_if.tuser = '0; u_if.tkeep = '0;
        #1 check_reset_state("rst0");
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;

        // Single TS1 with latency check: idle during the check cycle, pulse one cycle later.
        ts = mk_ts(8'h4A, 8'h10);
        send_beats(ts, 0, 3, 3, 1'b0);
        exp_ts(ts, 2'd1, 4'b0000);
        @(negedge clk_i);
        check_val("lat_early", 128'(os_valid_o), 0);
        drain();

        // 300 identical TS2: count saturates at 255.
        ts = mk_ts(8'h45, 8'h20);
        for (int n = 0; n < 300; n++) begin
            send_beats(ts, 0, 3, 3, 1'b0);
            exp_ts(ts, 2'd2, 4'b0000);
        end
        drain();
        check_val("cnt_sat_hold", 128'(consecutive_cnt_o), 255);

        // EIOS
        for (int i = 0; i < int'(L); i++) eios[128*i +: 128] = 128'h7C7C7CBC;
        send_beats(eios, 0, 0, 0, 1'b1);
        exp_eios();
        drain();

        // Lane 2 identifier mismatch
        ts = mk_ts(8'h4A, 8'h10);
        ts[128*2 + 8*9 +: 8] = 8'h45;
        send_beats(ts, 0, 3, 3, 1'b0);
        exp_ts(ts, 2'd1, 4'b0100);
        drain();

        // tlast on beat 1, then a good TS1
        ts = mk_ts(8'h4A, 8'h10);
        send_beats(ts, 0, 1, 1, 1'b0);
        exp_ferr();
        drain();
        send_beats(ts, 0, 3, 3, 1'b0);
        exp_ts(ts, 2'd1, 4'b0000);
        drain();

        // Beat 3 without tlast, two extra beats with tlast on the second
        ts = mk_ts(8'h45, 8'h30);
        send_beats(ts, 0, 3, -1, 1'b0);
        exp_ferr();
        send_beats(ts, 4, 5, 5, 1'b0);
        drain();
        check_stats("stats");

        // Reset after beat 2 of a TS
        ts = mk_ts(8'h4A, 8'h10);
        send_beats(ts, 0, 2, -1, 1'b0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1 check_reset_state("rst_mid");
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        send_beats(ts, 0, 3, 3, 1'b0);
        exp_ts(ts, 2'd1, 4'b0000);
        drain();
        check_val("post_rst_cnt", 128'(consecutive_cnt_o), 1);
        check_stats("stats_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
